// File: rtl/piso_4bit_left_shift_if.sv
// Parallel-load / serial-out bus for the PISO shift register.
// master: word source (drives load strobe and parallel word, sees serial bit)
// slave : shift register (consumes load and word, drives serial bit)
interface piso_4bit_left_shift_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out;

  modport master (
    output load,
    output parallel_in,
    input  serial_out
  );

  modport slave (
    input  load,
    input  parallel_in,
    output serial_out
  );
endinterface

// File: rtl/piso_4bit_left_shift.sv
// Parallel-in, serial-out left shift register. The MSB leaves first. A load
// strobe captures a word; otherwise the register shifts toward the MSB each
// cycle and the vacated LSB takes the FILL value.
module piso_4bit_left_shift #(
  parameter int unsigned WIDTH = 4,
  parameter logic        FILL  = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  piso_4bit_left_shift_if.slave        bus
);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;

  // Next value: a load replaces the word outright, otherwise shift left with FILL
  always_comb begin
    shift_next = {shift_reg[WIDTH-2:0], FILL};
    if (bus.load == 1'b1) begin
      shift_next = bus.parallel_in;
    end
  end

  // Register with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
    end else begin
      shift_reg <= shift_next;
    end
  end

  // Serial bit comes straight from the MSB flop, no extra stage
  assign bus.serial_out = shift_reg[WIDTH-1];

endmodule

// File: tb/tb_piso_4bit_left_shift.sv
// Bench for piso_4bit_left_shift: directed vector tables, hand-written reset
// sequences, an 8-bit FILL=1 instance, and random traffic against a bit-queue
// reference model.
module tb_piso_4bit_left_shift;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  piso_4bit_left_shift_if #(.WIDTH(4)) bus4 ();
  piso_4bit_left_shift_if #(.WIDTH(8)) bus8 ();

  piso_4bit_left_shift #(.WIDTH(4), .FILL(1'b0)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  piso_4bit_left_shift #(.WIDTH(8), .FILL(1'b1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [3:0] pin;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  // reference model: bits still to leave, front = current serial_out
  bit model_q[$];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: serial_out=%b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_q.delete();
    for (int i = 0; i < 4; i++) model_q.push_back(1'b0);
  endtask

  task automatic model_edge(input logic ld, input logic [3:0] pin);
    if (ld) begin
      model_q.delete();
      for (int i = 3; i >= 0; i--) model_q.push_back(pin[i]);
    end else begin
      void'(model_q.pop_front());
      model_q.push_back(1'b0);
    end
  endtask

  task automatic add(input logic ld, input logic [3:0] pin, input logic exp);
    vec_t v;
    v.load = ld;
    v.pin  = pin;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  logic [7:0] word8;
  logic [10:0] exp8;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus4.load = 1'b0;
    bus4.parallel_in = '0;
    bus8.load = 1'b0;
    bus8.parallel_in = '0;

    // Reset applied with no clock edge: output clears immediately
    #2;
    rst = 1'b0;
    #1;
    chk("reset_async_4", bus4.serial_out, 1'b0);
    chk("reset_async_8", bus8.serial_out, 1'b0);
    step();
    // reset overrides load
    bus4.load = 1'b1;
    bus4.parallel_in = 4'b1111;
    step();
    chk("reset_over_load", bus4.serial_out, 1'b0);
    bus4.load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_idle", bus4.serial_out, 1'b0);
    end

    // Directed tables: basic serialize, reload mid-shift, held load
    add(1, 4'b1011, 1); add(0, 4'b0000, 0); add(0, 4'b1111, 1);
    add(0, 4'b0000, 1); add(0, 4'b1111, 0); add(0, 4'b0000, 0);
    add(1, 4'b1011, 1); add(0, 4'b0000, 0); add(1, 4'b0100, 0);
    add(0, 4'b1111, 1); add(0, 4'b0000, 0); add(0, 4'b0000, 0);
    add(1, 4'b1000, 1); add(1, 4'b0111, 0); add(1, 4'b1111, 1);
    add(0, 4'b0000, 1); add(0, 4'b0000, 1); add(0, 4'b0000, 1);
    add(0, 4'b0000, 0); add(0, 4'b0000, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      bus4.load = vecs[i].load;
      bus4.parallel_in = vecs[i].pin;
      step();
      chk($sformatf("vec%0d", i), bus4.serial_out, vecs[i].exp);
    end
    bus4.load = 1'b0;

    // Async reset mid-stream
    bus4.load = 1'b1;
    bus4.parallel_in = 4'b1111;
    step();
    chk("mid_load", bus4.serial_out, 1'b1);
    bus4.load = 1'b0;
    step();
    chk("mid_shift", bus4.serial_out, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_reset_async", bus4.serial_out, 1'b0);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_reset_after", bus4.serial_out, 1'b0);
    end

    // X on inputs outside a load edge must not disturb the word
    bus4.load = 1'b1;
    bus4.parallel_in = 4'b1010;
    step();
    bus4.load = 1'b0;
    bus4.parallel_in = 4'bxxxx;
    step();
    chk("x_pin_shift0", bus4.serial_out, 1'b0);
    step();
    chk("x_pin_shift1", bus4.serial_out, 1'b1);
    bus4.parallel_in = '0;

    // WIDTH=8, FILL=1: 0x5A then constant 1
    word8 = 8'h5A;
    exp8  = {word8, 3'b111};
    bus8.load = 1'b1;
    bus8.parallel_in = word8;
    step();
    bus8.load = 1'b0;
    chk("w8_bit0", bus8.serial_out, exp8[10]);
    for (int k = 1; k < 11; k++) begin
      step();
      chk($sformatf("w8_bit%0d", k), bus8.serial_out, exp8[10-k]);
    end

    // Random traffic against the queue model (starts from a clean reset)
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 300; i++) begin
      bus4.load = ($urandom_range(0, 3) == 0);
      bus4.parallel_in = 4'($urandom);
      model_edge(bus4.load, bus4.parallel_in);
      step();
      chk("random", bus4.serial_out, model_q[0]);
    end
    bus4.load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
